// File: rtl/atp_pkg.sv
// atp_pkg: shared widths, FSM states and fail causes for the atp session arbiter
package atp_pkg;
  localparam int BARCODE_W = 4;
  localparam int AMT_W = 8;
  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_e;
  typedef enum logic [1:0] {NONE, DISC, ABORT, TIMEOUT} fail_cause_e;
endpackage

// File: rtl/atp_session_arbiter_if.sv
// atp_session_arbiter_if: terminal-side and atp-side signals of the session arbiter
interface atp_session_arbiter_if #(
  parameter int NUM_TERM = 4
);
  import atp_pkg::*;
  localparam int IW = $clog2(NUM_TERM);
  logic [NUM_TERM-1:0] term_req;
  logic [NUM_TERM*BARCODE_W-1:0] term_barcode;
  logic [NUM_TERM-1:0] term_grant;
  logic [NUM_TERM-1:0] term_done;
  logic [NUM_TERM-1:0] term_fail;
  logic atp_start_payment;
  logic [BARCODE_W-1:0] atp_barcode;
  logic atp_payment_complete;
  logic atp_line_disconnected;
  logic [AMT_W-1:0] atp_remaining_amount;
  logic busy;
  logic [IW-1:0] grant_id;
  logic [AMT_W-1:0] last_remaining;
  modport master (
    input term_req, term_barcode, atp_payment_complete, atp_line_disconnected, atp_remaining_amount,
    output term_grant, term_done, term_fail, atp_start_payment, atp_barcode, busy, grant_id, last_remaining
  );
  modport slave (
    output term_req, term_barcode, atp_payment_complete, atp_line_disconnected, atp_remaining_amount,
    input term_grant, term_done, term_fail, atp_start_payment, atp_barcode, busy, grant_id, last_remaining
  );
endinterface

// File: rtl/atp_rr_picker.sv
// atp_rr_picker: combinational round-robin pick, searching upward from rr_ptr+1 with wrap
module atp_rr_picker #(
  parameter int NUM_TERM = 4,
  localparam int IW = $clog2(NUM_TERM)
) (
  input  logic [NUM_TERM-1:0] req,
  input  logic [IW-1:0]       rr_ptr,
  output logic [NUM_TERM-1:0] grant,
  output logic [IW-1:0]       idx,
  output logic                valid
);
  logic [IW-1:0] k;
  // walk from lowest to highest priority so the nearest requester after rr_ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    k = '0;
    valid = |req;
    for (int i = NUM_TERM; i >= 1; i--) begin
      k = IW'((int'(rr_ptr) + i) % NUM_TERM);
      if (req[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/atp_session_arbiter.sv
// atp_session_arbiter: round-robin payment-session arbiter for one atp engine; WAIT timeout enabled by ATP_ARB_TIMEOUT_EN
module atp_session_arbiter
  import atp_pkg::*;
#(
  parameter int NUM_TERM = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input logic clk,
  input logic reset,
  atp_session_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_TERM);
  state_e state_q, state_d;
  fail_cause_e cause;
  logic [NUM_TERM-1:0] grant_q, grant_d, done_q, done_d, fail_q, fail_d, p_grant;
  logic [IW-1:0] id_q, id_d, rr_q, rr_d, p_idx;
  logic [BARCODE_W-1:0] barcode_q, barcode_d;
  logic [AMT_W-1:0] last_q, last_d;
  logic start_q, start_d, busy_q, busy_d, p_valid, timeout;
  if (NUM_TERM < 2 || NUM_TERM > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("atp_session_arbiter: parameter out of range");
  end
`ifdef ATP_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer_q, timer_d;
  // held at zero until the session starts, so START sees a cleared timer
  always_comb timer_d = (state_q == IDLE) ? '0 : (timer_q == TW'(TIMEOUT_CYC)) ? timer_q : timer_q + TW'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_q <= '0;
    else timer_q <= timer_d;
  end
  assign timeout = timer_q == TW'(TIMEOUT_CYC - 1);
`else
  assign timeout = 1'b0;
`endif
  atp_rr_picker #(.NUM_TERM(NUM_TERM)) u_pick (
    .req(bus.term_req),
    .rr_ptr(rr_q),
    .grant(p_grant),
    .idx(p_idx),
    .valid(p_valid)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d = id_q;
    barcode_d = barcode_q;
    last_d = last_q;
    rr_d = rr_q;
    start_d = 1'b0;
    done_d = '0;
    fail_d = '0;
    cause = NONE;
    if (state_q == IDLE && p_valid) begin
      state_d = START;
      grant_d = p_grant;
      id_d = p_idx;
      barcode_d = bus.term_barcode[p_idx*BARCODE_W +: BARCODE_W];
      start_d = 1'b1;
    end
    if (state_q == START) state_d = WAIT;
    if (state_q == WAIT) begin
      cause = bus.atp_line_disconnected ? DISC : !bus.term_req[id_q] ? ABORT : timeout ? TIMEOUT : NONE;
      if (bus.atp_payment_complete || cause != NONE) begin
        state_d = RELEASE;
        grant_d = '0;
        last_d = bus.atp_remaining_amount;
        done_d = bus.atp_payment_complete ? grant_q : '0;
        fail_d = bus.atp_payment_complete ? '0 : grant_q;
      end
    end
    if (state_q == RELEASE) begin
      state_d = IDLE;
      rr_d = id_q;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q <= '0;
      rr_q <= IW'(NUM_TERM - 1);
      barcode_q <= '0;
      last_q <= '0;
      start_q <= 1'b0;
      done_q <= '0;
      fail_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q <= id_d;
      rr_q <= rr_d;
      barcode_q <= barcode_d;
      last_q <= last_d;
      start_q <= start_d;
      done_q <= done_d;
      fail_q <= fail_d;
      busy_q <= busy_d;
    end
  end
  assign bus.term_grant = grant_q;
  assign bus.term_done = done_q;
  assign bus.term_fail = fail_q;
  assign bus.atp_start_payment = start_q;
  assign bus.atp_barcode = barcode_q;
  assign bus.busy = busy_q;
  assign bus.grant_id = id_q;
  assign bus.last_remaining = last_q;
endmodule

// File: tb/tb_atp_session_arbiter.sv
// tb_atp_session_arbiter: directed checks of arbitration, session sequencing and reset
module tb_atp_session_arbiter;
  import atp_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  atp_session_arbiter_if #(.NUM_TERM(N)) bus ();
  atp_session_arbiter #(.NUM_TERM(N), .TIMEOUT_CYC(200)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.term_req = '0;
    bus.term_barcode = '0;
    bus.atp_payment_complete = 1'b0;
    bus.atp_line_disconnected = 1'b0;
    bus.atp_remaining_amount = '0;
  endtask
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
  endtask
  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) cyc();
    total++; if (bus.term_grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", bus.term_grant); end
    total++; if ({bus.term_done, bus.term_fail} !== 8'h00) begin bad++; $display("FAIL rst_done_fail got=%b want=00000000", {bus.term_done, bus.term_fail}); end
    total++; if ({bus.atp_start_payment, bus.busy} !== 2'b00) begin bad++; $display("FAIL rst_start_busy got=%b want=00", {bus.atp_start_payment, bus.busy}); end
    total++; if ({bus.grant_id, bus.atp_barcode, bus.last_remaining} !== 14'h0) begin bad++; $display("FAIL rst_regs got=%h want=0", {bus.grant_id, bus.atp_barcode, bus.last_remaining}); end
    reset = 1'b1;
    cyc();
    total++; if ({bus.busy, bus.term_grant} !== 5'b0) begin bad++; $display("FAIL rst_idle got=%b want=00000", {bus.busy, bus.term_grant}); end
  endtask
  task automatic test_single();
    bus.term_barcode = 16'h0002;
    bus.term_req = 4'b0001;
    cyc();
    total++; if (bus.term_grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", bus.term_grant); end
    total++; if (bus.atp_start_payment !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", bus.atp_start_payment); end
    total++; if (bus.atp_barcode !== 4'd2) begin bad++; $display("FAIL single_barcode got=%0d want=2", bus.atp_barcode); end
    total++; if ({bus.busy, bus.grant_id} !== 3'b100) begin bad++; $display("FAIL single_busy_id got=%b want=100", {bus.busy, bus.grant_id}); end
    bus.term_barcode = 16'h0009;
    cyc();
    total++; if ({bus.atp_start_payment, bus.term_grant} !== 5'b00001) begin bad++; $display("FAIL single_start_pulse got=%b want=00001", {bus.atp_start_payment, bus.term_grant}); end
    repeat (9) cyc();
    bus.atp_payment_complete = 1'b1;
    bus.atp_remaining_amount = 8'd0;
    cyc();
    bus.atp_payment_complete = 1'b0;
    bus.term_req = 4'b0000;
    total++; if ({bus.term_done, bus.term_fail} !== 8'b0001_0000) begin bad++; $display("FAIL single_done got=%b want=00010000", {bus.term_done, bus.term_fail}); end
    total++; if ({bus.busy, bus.term_grant, bus.last_remaining} !== 13'h1000) begin bad++; $display("FAIL single_release got=%h want=1000", {bus.busy, bus.term_grant, bus.last_remaining}); end
    cyc();
    total++; if ({bus.busy, bus.term_done} !== 5'b0) begin bad++; $display("FAIL single_idle got=%b want=00000", {bus.busy, bus.term_done}); end
    total++; if (bus.atp_barcode !== 4'd2) begin bad++; $display("FAIL single_barcode_hold got=%0d want=2", bus.atp_barcode); end
  endtask
  task automatic test_round_robin();
    apply_reset();
    bus.term_barcode = {4'd8, 4'd7, 4'd6, 4'd5};
    bus.term_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % N;
      cyc();
      total++; if (bus.term_grant !== (4'b0001 << e)) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, bus.term_grant, 4'b0001 << e); end
      total++; if (bus.grant_id !== 2'(e) || bus.atp_barcode !== 4'(5 + e)) begin bad++; $display("FAIL rr_id_bc%0d got=%0d/%0d want=%0d/%0d", k, bus.grant_id, bus.atp_barcode, e, 5 + e); end
      cyc();
      bus.atp_payment_complete = 1'b1;
      bus.atp_remaining_amount = 8'(20 + k);
      cyc();
      bus.atp_payment_complete = 1'b0;
      total++; if (bus.term_done !== (4'b0001 << e) || bus.last_remaining !== 8'(20 + k)) begin bad++; $display("FAIL rr_done%0d got=%b/%0d want=%b/%0d", k, bus.term_done, bus.last_remaining, 4'b0001 << e, 20 + k); end
      cyc();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rr_gap%0d got=%b want=0", k, bus.busy); end
    end
    bus.term_req = 4'b0000;
    cyc();
  endtask
  task automatic test_disconnect();
    bus.term_req = 4'b0100;
    cyc();
    total++; if (bus.term_grant !== 4'b0100) begin bad++; $display("FAIL disc_grant got=%b want=0100", bus.term_grant); end
    cyc();
    bus.atp_line_disconnected = 1'b1;
    bus.atp_remaining_amount = 8'd33;
    cyc();
    bus.atp_line_disconnected = 1'b0;
    total++; if ({bus.term_done, bus.term_fail} !== 8'b0000_0100) begin bad++; $display("FAIL disc_fail got=%b want=00000100", {bus.term_done, bus.term_fail}); end
    total++; if (bus.last_remaining !== 8'd33) begin bad++; $display("FAIL disc_last got=%0d want=33", bus.last_remaining); end
    repeat (2) cyc();
    cyc();
    bus.atp_payment_complete = 1'b1;
    bus.atp_line_disconnected = 1'b1;
    bus.atp_remaining_amount = 8'd44;
    cyc();
    bus.atp_payment_complete = 1'b0;
    bus.atp_line_disconnected = 1'b0;
    bus.term_req = 4'b0000;
    total++; if ({bus.term_done, bus.term_fail} !== 8'b0100_0000) begin bad++; $display("FAIL both_done_only got=%b want=01000000", {bus.term_done, bus.term_fail}); end
    total++; if (bus.last_remaining !== 8'd44) begin bad++; $display("FAIL both_last got=%0d want=44", bus.last_remaining); end
    cyc();
  endtask
  task automatic test_abort();
    bus.term_req = 4'b0010;
    cyc();
    total++; if (bus.grant_id !== 2'd1) begin bad++; $display("FAIL abort_id got=%0d want=1", bus.grant_id); end
    repeat (2) cyc();
    total++; if ({bus.term_grant, bus.term_fail} !== 8'b0010_0000) begin bad++; $display("FAIL abort_wait got=%b want=00100000", {bus.term_grant, bus.term_fail}); end
    bus.term_req = 4'b0000;
    cyc();
    total++; if ({bus.busy, bus.term_done, bus.term_fail} !== 9'b1_0000_0010) begin bad++; $display("FAIL abort_fail got=%b want=100000010", {bus.busy, bus.term_done, bus.term_fail}); end
    cyc();
    total++; if ({bus.busy, bus.term_fail} !== 5'b0) begin bad++; $display("FAIL abort_idle got=%b want=00000", {bus.busy, bus.term_fail}); end
  endtask
  task automatic test_timeout();
    int n;
    n = 0;
    bus.term_req = 4'b1000;
    cyc();
`ifdef ATP_ARB_TIMEOUT_EN
    while (bus.term_fail === 4'b0000 && n < 300) begin
      cyc();
      n++;
    end
    total++; if (n !== 200) begin bad++; $display("FAIL timeout_cycles got=%0d want=200", n); end
    total++; if (bus.term_fail !== 4'b1000) begin bad++; $display("FAIL timeout_fail got=%b want=1000", bus.term_fail); end
`else
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (bus.term_fail !== 4'b0000) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL no_timeout got=%0d fail cycles want=0", n); end
    total++; if ({bus.busy, bus.term_grant} !== 5'b11000) begin bad++; $display("FAIL no_timeout_held got=%b want=11000", {bus.busy, bus.term_grant}); end
    bus.atp_payment_complete = 1'b1;
    cyc();
    bus.atp_payment_complete = 1'b0;
    total++; if (bus.term_done !== 4'b1000) begin bad++; $display("FAIL no_timeout_done got=%b want=1000", bus.term_done); end
`endif
    bus.term_req = 4'b0000;
    repeat (2) cyc();
  endtask
  task automatic test_reset_mid();
    bus.term_req = 4'b0010;
    repeat (2) cyc();
    bus.atp_payment_complete = 1'b1;
    cyc();
    bus.atp_payment_complete = 1'b0;
    bus.term_req = 4'b0100;
    repeat (5) cyc();
    total++; if (bus.term_grant !== 4'b0100) begin bad++; $display("FAIL mid_grant got=%b want=0100", bus.term_grant); end
    reset = 1'b0;
    #1;
    total++; if ({bus.term_grant, bus.busy, bus.grant_id, bus.atp_barcode, bus.atp_start_payment} !== 12'h0) begin bad++; $display("FAIL mid_async got=%h want=0", {bus.term_grant, bus.busy, bus.grant_id, bus.atp_barcode, bus.atp_start_payment}); end
    cyc();
    total++; if ({bus.term_done, bus.term_fail, bus.last_remaining} !== 16'h0) begin bad++; $display("FAIL mid_no_pulse got=%h want=0", {bus.term_done, bus.term_fail, bus.last_remaining}); end
    reset = 1'b1;
    bus.term_req = 4'b1111;
    cyc();
    total++; if (bus.term_grant !== 4'b0001 || bus.grant_id !== 2'd0) begin bad++; $display("FAIL mid_prio got=%b/%0d want=0001/0", bus.term_grant, bus.grant_id); end
    bus.term_req = 4'b0000;
    repeat (3) cyc();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_disconnect();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/atp_session_arbiter.md
Name: atp_session_arbiter

Overview:
- Shares one atp payment engine among NUM_TERM kiosk terminals; grants one payment session at a time, round-robin.
- Sequences the engine per session: latches the barcode, issues a one-cycle start_payment pulse, waits for completion, disconnect, timeout or abort, then releases.
- Reports per-terminal done/fail and the final remaining_amount. Sits between the terminal front-ends and the atp instance.

Parameters:
- NUM_TERM, 4, number of requesting terminals (2..8)
- BARCODE_W, 4, barcode width, matches atp barcode port
- AMT_W, 8, amount width, matches atp remaining_amount
- TIMEOUT_CYC, 200, max cycles in WAIT before forced fail (ATP_ARB_TIMEOUT_EN only)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- term_req  in  NUM_TERM  level request per terminal; hold until done/fail
- term_barcode  in  NUM_TERM*BARCODE_W  packed barcodes, terminal i at [i*BARCODE_W +: BARCODE_W]
- term_grant  out  NUM_TERM  one-hot grant, high for the whole session
- term_done  out  NUM_TERM  one-cycle pulse: session paid
- term_fail  out  NUM_TERM  one-cycle pulse: disconnect, timeout or abort
- atp_start_payment  out  1  one-cycle start pulse to atp
- atp_barcode  out  BARCODE_W  latched barcode, stable for the whole session
- atp_payment_complete  in  1  from atp
- atp_line_disconnected  in  1  from atp
- atp_remaining_amount  in  AMT_W  from atp
- busy  out  1  high in any state except IDLE
- grant_id  out  $clog2(NUM_TERM)  index of the current/last granted terminal
- last_remaining  out  AMT_W  atp_remaining_amount captured at session end

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = NUM_TERM-1 so terminal 0 has first priority.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, RELEASE.
- IDLE:
  - Any term_req set -> round-robin pick, searching from rr_ptr+1 with wrap-around.
  - Register grant one-hot, grant_id and atp_barcode; go to START.
  - Latency: request seen at edge N -> term_grant and atp_start_payment high after edge N+1.
- START:
  - atp_start_payment = 1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT, evaluated in this priority order:
  - atp_payment_complete -> term_done[id] pulse.
  - else atp_line_disconnected -> term_fail[id] pulse.
  - else term_req[id] low -> abort, term_fail[id] pulse.
  - else timer == TIMEOUT_CYC-1 -> term_fail[id] pulse.
  - On any of the above exit: capture last_remaining; go to RELEASE.
  - complete and disconnect in the same cycle -> done wins.
- RELEASE:
  - One cycle; term_grant cleared; rr_ptr <= grant_id; go to IDLE.
  - The atp needs this idle gap between sessions.
  - Minimum session = 4 cycles request-to-next-grant.
- Fairness: the just-served terminal has lowest priority next arbitration even if its term_req is still high.
- Requests arriving in non-IDLE states are held pending, not lost (level-sensitive).
- term_req changes from non-granted terminals during a session are ignored.
- atp_barcode holds its value after the session until the next grant.
- Reset asserted mid-session: immediate return to IDLE, all outputs 0, no done/fail pulse.
- Timer is $clog2(TIMEOUT_CYC+1) bits, saturating, cleared in START.

Optional Feature:
- Macro: ATP_ARB_TIMEOUT_EN
- Defined: WAIT timeout as above.
- Undefined: no timer logic; WAIT exits only on complete, disconnect or abort.

Decomposition:
- Shared package atp_pkg: state enum (IDLE/START/WAIT/RELEASE), BARCODE_W and AMT_W constants, and a fail-cause enum (DISC/ABORT/TIMEOUT) for debug.
- One sub-module: atp_rr_picker, combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, index, valid.

Test Plan:
- Reset, then term_req=4'b0001, barcode0=2 -> grant[0] and start pulse 1 cycle later, atp_barcode=2. Complete after 10 cycles, remaining=0 -> done[0] pulse, last_remaining=0, busy low 2 cycles after complete.
- term_req=4'b1111 held, each session completed -> grant order 0,1,2,3,0; no terminal granted twice in a row.
- Terminal 2 granted, line_disconnected=1 -> fail[2] pulse, done stays 0.
  - Same-cycle complete+disconnect -> done[2] only.
- Terminal 1 granted, drops term_req in WAIT -> fail[1] next edge, RELEASE, IDLE.
- ATP_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=200, no response -> fail exactly 200 cycles after START. Undefined -> no fail after 1000 cycles.
- Reset driven low mid-WAIT -> all outputs 0 asynchronously; after release, terminal 0 has priority again.
